// File: rtl/exec_monitor.sv
// Run monitor for the pipelined MIPS core: counts run cycles and events, detects the
// finish store, then drives the dmem read port and streams result words over valid/ready.
module exec_monitor #(
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       ADDR_W      = 16,
    parameter int unsigned       CNT_W       = 32,
    parameter int unsigned       N_EVT       = 4,
    parameter logic [DATA_W-1:0] FINISH_ADDR = DATA_W'(32'h7fff),
    parameter int unsigned       MAX_CYCLES  = 100000,
    parameter int unsigned       DUMP_WORDS  = 50
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run,
    input  logic [N_EVT-1:0]        evt,
    input  logic [DATA_W-1:0]       daddr,
    input  logic                    dwe,
    input  logic [DATA_W-1:0]       dwdata,
    output logic                    halt,
    output logic                    mem_sel,
    output logic [ADDR_W-1:0]       dump_addr,
    input  logic [DATA_W-1:0]       dump_rdata,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic [ADDR_W-1:0]       out_index,
    output logic                    done,
    output logic                    timeout,
    output logic [DATA_W-1:0]       result,
    output logic [CNT_W-1:0]        cycle_count,
    output logic [N_EVT*CNT_W-1:0]  evt_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DUMP = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    // Compared in 64 bits so a narrow counter never aliases onto the limit.
    localparam logic [63:0]       CYCLE_LIMIT = 64'(MAX_CYCLES) - 64'd1;
    localparam logic [ADDR_W-1:0] LAST_INDEX  = ADDR_W'(DUMP_WORDS - 1);

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic              count_en;
    logic              finish_hit;
    logic              timeout_hit;
    logic              beat;
    logic              at_limit;
    logic [ADDR_W-1:0] index;
    logic [CNT_W-1:0]  evt_cnt [N_EVT];

    assign at_limit  = (64'(cycle_count) == CYCLE_LIMIT);
    assign beat      = out_valid && out_ready;
    assign dump_addr = index;
    assign out_index = index;
    assign out_data  = dump_rdata;

    for (genvar g = 0; g < N_EVT; g++) begin : g_evt
        assign evt_count[g*CNT_W +: CNT_W] = evt_cnt[g];
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and datapath strobes; finish has priority over timeout
    always_comb begin
        state_next  = state;
        count_en    = 1'b0;
        finish_hit  = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (run) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (run) begin
                    count_en = 1'b1;
                    if (dwe && (daddr == FINISH_ADDR)) begin
                        finish_hit = 1'b1;
                        state_next = DUMP;
                    end else if (at_limit) begin
                        timeout_hit = 1'b1;
                        state_next  = DONE;
                    end
                end
            end
            DUMP: begin
                if (beat && (index == LAST_INDEX)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = DONE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered status outputs follow the next state so they line up with it
    always_ff @(posedge clk) begin
        if (rst) begin
            halt      <= 1'b0;
            mem_sel   <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            halt      <= (state_next == DUMP) || (state_next == DONE);
            mem_sel   <= (state_next == DUMP);
            out_valid <= (state_next == DUMP);
            done      <= (state_next == DONE);
        end
    end

    // Saturating run and event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count <= '0;
            for (int i = 0; i < int'(N_EVT); i++) begin
                evt_cnt[i] <= '0;
            end
        end else if (count_en) begin
            if (cycle_count != '1) begin
                cycle_count <= cycle_count + CNT_W'(1);
            end
            for (int i = 0; i < int'(N_EVT); i++) begin
                if (evt[i] && (evt_cnt[i] != '1)) begin
                    evt_cnt[i] <= evt_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Result capture, timeout flag and dump index
    always_ff @(posedge clk) begin
        if (rst) begin
            result  <= '0;
            timeout <= 1'b0;
            index   <= '0;
        end else begin
            if (finish_hit) begin
                result <= dwdata;
                index  <= '0;
            end else if (beat) begin
                index <= index + ADDR_W'(1);
            end
            if (timeout_hit) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_exec_monitor.sv
// Scoreboard bench for exec_monitor: expected dump words are queued by the stimulus and
// checked by an independent monitor; a narrow-counter instance covers saturation.
module tb_exec_monitor;

    localparam int unsigned N_EVT   = 4;
    localparam int unsigned MAX_A   = 30;
    localparam int unsigned WORDS_A = 4;

    typedef struct packed {
        logic [15:0] idx;
        logic [31:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run = 1'b0;
    logic run_b = 1'b0;
    logic dwe = 1'b0;
    logic out_ready = 1'b0;
    logic [N_EVT-1:0] evt = '0;
    logic [31:0] daddr = '0;
    logic [31:0] dwdata = '0;

    logic        halt, mem_sel, out_valid, done, timeout;
    logic [15:0] dump_addr, out_index;
    logic [31:0] dump_rdata, out_data, result, cycle_count;
    logic [127:0] evt_count;

    logic        halt_b, mem_sel_b, out_valid_b, done_b, timeout_b;
    logic [15:0] dump_addr_b, out_index_b;
    logic [31:0] dump_rdata_b, out_data_b, result_b;
    logic [3:0]  cycle_count_b;
    logic [15:0] evt_count_b;

    logic [31:0] mem [0:63];
    beat_t sb[$];
    int n_checks = 0;
    int n_fail = 0;
    int hs_count = 0;
    int waited;

    assign dump_rdata   = mem[dump_addr[5:0]];
    assign dump_rdata_b = {16'hbeef, dump_addr_b};

    always #5 clk = ~clk;

    exec_monitor #(
        .CNT_W(32), .N_EVT(N_EVT), .MAX_CYCLES(MAX_A), .DUMP_WORDS(WORDS_A)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .evt(evt), .daddr(daddr), .dwe(dwe),
        .dwdata(dwdata), .halt(halt), .mem_sel(mem_sel), .dump_addr(dump_addr),
        .dump_rdata(dump_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index), .done(done), .timeout(timeout),
        .result(result), .cycle_count(cycle_count), .evt_count(evt_count)
    );

    exec_monitor #(
        .CNT_W(4), .N_EVT(N_EVT), .DUMP_WORDS(1)
    ) dut_b (
        .clk(clk), .rst(rst), .run(run_b), .evt(evt), .daddr(daddr), .dwe(dwe),
        .dwdata(dwdata), .halt(halt_b), .mem_sel(mem_sel_b), .dump_addr(dump_addr_b),
        .dump_rdata(dump_rdata_b), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .out_index(out_index_b), .done(done_b),
        .timeout(timeout_b), .result(result_b), .cycle_count(cycle_count_b),
        .evt_count(evt_count_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; run_b = 1'b0; dwe = 1'b0; evt = '0; out_ready = 1'b0;
        tick();
        tick();
        sb.delete();
        hs_count = 0;
        rst = 1'b0;
    endtask

    task automatic finish_store(input logic [31:0] value);
        dwe = 1'b1; daddr = 32'h7fff; dwdata = value;
        tick();
        dwe = 1'b0; daddr = '0; dwdata = '0; evt = '0;
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            sb.push_back('{idx: 16'(i), data: mem[i]});
        end
    endtask

    task automatic wait_done(input int bound, output int n);
        n = 0;
        while (!done && n < bound) begin
            tick();
            n++;
        end
        check("done_within_bound", 64'(done), 64'd1);
    endtask

    // Monitor: every presented word must match the queue head; pop on handshake
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_word: index %0d data %0h, no word expected",
                             out_index, out_data);
                end else if (out_index !== sb[0].idx || out_data !== sb[0].data) begin
                    n_fail++;
                    $display("FAIL dump_word: index %0d data %0h, required index %0d data %0h",
                             out_index, out_data, sb[0].idx, sb[0].data);
                end
                if (out_ready && sb.size() > 0) begin
                    void'(sb.pop_front());
                    hs_count++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h100 + 32'(i);

        // Reset values
        do_reset();
        check("rst_halt", 64'(halt), 64'd0);
        check("rst_mem_sel", 64'(mem_sel), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_flags", 64'({done, timeout}), 64'd0);
        check("rst_counts", 64'(cycle_count) | 64'(evt_count[63:0]), 64'd0);
        check("rst_result_index", 64'({result, out_index}), 64'd0);

        // Basic finish with event pulses, store on the 21st run cycle
        push_words(WORDS_A);
        out_ready = 1'b1;
        run = 1'b1;
        tick();
        check("idle_no_count", 64'(cycle_count), 64'd0);
        for (int i = 0; i < 20; i++) begin
            evt[0] = (i == 2 || i == 5 || i == 8 || i == 11);
            evt[3] = (i == 7);
            tick();
        end
        evt = 4'b1001;
        finish_store(32'h0000_00aa);
        check("finish_halt", 64'(halt), 64'd1);
        check("finish_mem_sel", 64'(mem_sel), 64'd1);
        check("finish_result", 64'(result), 64'haa);
        check("finish_cycles", 64'(cycle_count), 64'd21);
        check("evt0", 64'(evt_count[31:0]), 64'd5);
        check("evt1_evt2", 64'(evt_count[95:32]), 64'd0);
        check("evt3", 64'(evt_count[127:96]), 64'd2);
        wait_done(20, waited);
        check("dump_cycles", 64'(waited), 64'(WORDS_A));
        check("basic_handshakes", 64'(hs_count), 64'(WORDS_A));
        check("basic_after", 64'({halt, out_valid, timeout}), 64'b100);

        // Backpressure: words 1..4, ready toggling
        do_reset();
        for (int i = 0; i < 4; i++) mem[i] = 32'(i + 1);
        push_words(WORDS_A);
        run = 1'b1;
        tick();
        tick();
        tick();
        finish_store(32'h55);
        for (int k = 0; k < 40 && !done; k++) begin
            out_ready = ~out_ready;
            tick();
        end
        check("bp_done", 64'(done), 64'd1);
        check("bp_handshakes", 64'(hs_count), 64'd4);
        check("bp_queue_empty", 64'(sb.size()), 64'd0);
        for (int i = 0; i < 4; i++) mem[i] = 32'h100 + 32'(i);

        // Timeout with a 3-cycle pause and stray stores
        do_reset();
        out_ready = 1'b1;
        run = 1'b1;
        tick();
        for (int k = 0; k < 32; k++) begin
            run = !(k >= 10 && k < 13);
            dwe = (k == 5 || k == 6);
            daddr = (k == 5) ? 32'h7ffe : 32'h0001_7fff;
            tick();
        end
        dwe = 1'b0;
        daddr = '0;
        check("pre_timeout_cycles", 64'(cycle_count), 64'd29);
        check("pre_timeout_flag", 64'({timeout, done}), 64'd0);
        run = 1'b1;
        tick();
        check("timeout_flag", 64'(timeout), 64'd1);
        check("timeout_done", 64'(done), 64'd1);
        check("timeout_cycles", 64'(cycle_count), 64'(MAX_A));
        check("timeout_no_dump", 64'({halt, mem_sel}), 64'b10);
        evt = 4'b1111;
        tick();
        tick();
        evt = '0;
        check("done_frozen", 64'(cycle_count) | 64'(evt_count[31:0]) << 32, 64'(MAX_A));

        // Finish lands on the timeout cycle: finish wins
        do_reset();
        push_words(WORDS_A);
        out_ready = 1'b1;
        run = 1'b1;
        tick();
        for (int k = 0; k < 29; k++) tick();
        finish_store(32'hc011);
        check("coll_dump", 64'(mem_sel), 64'd1);
        check("coll_timeout", 64'(timeout), 64'd0);
        check("coll_cycles", 64'(cycle_count), 64'(MAX_A));
        check("coll_result", 64'(result), 64'hc011);
        wait_done(20, waited);
        check("coll_timeout_after", 64'(timeout), 64'd0);
        check("coll_handshakes", 64'(hs_count), 64'(WORDS_A));

        // Reset mid-dump, then a clean re-run
        do_reset();
        push_words(WORDS_A);
        out_ready = 1'b1;
        run = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) tick();
        finish_store(32'h77);
        for (int k = 0; k < 10 && out_index != 16'd2; k++) tick();
        check("middump_index", 64'(out_index), 64'd2);
        rst = 1'b1;
        run = 1'b0;
        out_ready = 1'b0;
        tick();
        check("middump_rst_ctrl", 64'({halt, mem_sel, out_valid, done}), 64'd0);
        check("middump_rst_data", 64'({out_index, result}), 64'd0);
        check("middump_rst_cnt", 64'(cycle_count), 64'd0);
        sb.delete();
        hs_count = 0;
        rst = 1'b0;
        push_words(WORDS_A);
        out_ready = 1'b1;
        run = 1'b1;
        tick();
        check("rerun_no_halt", 64'(halt), 64'd0);
        for (int k = 0; k < 3; k++) tick();
        finish_store(32'h78);
        wait_done(20, waited);
        check("rerun_handshakes", 64'(hs_count), 64'(WORDS_A));
        check("rerun_result", 64'(result), 64'h78);

        // Saturation on the 4-bit counter instance
        do_reset();
        run_b = 1'b1;
        tick();
        evt = 4'b0001;
        for (int k = 0; k < 19; k++) tick();
        finish_store(32'h1234);
        check("sat_cycles", 64'(cycle_count_b), 64'hf);
        check("sat_evt0", 64'(evt_count_b[3:0]), 64'hf);
        check("sat_evt_rest", 64'(evt_count_b[15:4]), 64'd0);
        check("sat_result", 64'(result_b), 64'h1234);
        check("sat_word", 64'({out_valid_b, out_data_b}), {31'd0, 1'b1, 32'hbeef_0000});
        out_ready = 1'b1;
        tick();
        check("sat_done", 64'({done_b, timeout_b}), 64'b10);
        check("sat_other_idle", 64'(cycle_count), 64'd0);
        run_b = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_monitor.md
# exec_monitor

Synthesizable run monitor for the pipelined MIPS core. It replaces the behavioural finish/count logic of the simulation bench with hardware. It counts run cycles and up to N_EVT event channels (stall, flush, and so on), and detects the finish store to FINISH_ADDR. It then takes over the data-memory read port and streams DUMP_WORDS result words out over a valid/ready interface. It sits beside the dmem at top level and works in both simulation and FPGA builds.

## Interface
Parameters:
- DATA_W, 32, datapath and address width
- ADDR_W, 16, dmem word-address width
- CNT_W, 32, width of each counter
- N_EVT, 4, number of event channels; channel 0 is the pipeline stall
- FINISH_ADDR, 32'h7fff, byte address whose store ends the run
- MAX_CYCLES, 100000, run-cycle limit before timeout
- DUMP_WORDS, 50, number of dmem words to stream after finish (≥1)

Ports (one clock; reset is synchronous and active-high):
- clk, in, 1, clock; all state changes on the rising edge
- rst, in, 1, synchronous active-high reset
- run, in, 1, core enable; counting is paused while low
- evt, in, N_EVT, per-channel event strobes, sampled each RUN cycle
- daddr, in, DATA_W, core data address (aluout)
- dwe, in, 1, core memwrite
- dwdata, in, DATA_W, core write data
- halt, out, 1, freezes the core in DUMP and DONE
- mem_sel, out, 1, high in DUMP; top level muxes dmem address to dump_addr
- dump_addr, out, ADDR_W, dmem word address during dump
- dump_rdata, in, DATA_W, dmem asynchronous read data
- out_valid, out, 1, dump word valid
- out_ready, in, 1, sink ready
- out_data, out, DATA_W, dump word (= dump_rdata)
- out_index, out, ADDR_W, index of the current dump word
- done, out, 1, sticky completion flag
- timeout, out, 1, sticky: run ended on MAX_CYCLES
- result, out, DATA_W, dwdata captured at the finish store
- cycle_count, out, CNT_W, run cycles
- evt_count, out, N_EVT*CNT_W, channel i in bits [i*CNT_W +: CNT_W]

## Operation
- FSM states: IDLE, RUN, DUMP, DONE.
- Reset values: state IDLE; all counters, result, dump index and flags 0; halt=0, mem_sel=0, out_valid=0.
- IDLE:
  - Goes to RUN the cycle after run=1 is sampled.
  - Nothing is counted in IDLE.
- RUN:
  - Each edge with run=1: cycle_count+1, and evt_count[i]+1 for every evt[i]=1.
  - With run=0: all counters hold; state stays RUN.
  - Counters saturate at all-ones and never wrap.
  - Finish: run=1 && dwe && daddr==FINISH_ADDR (full-width compare). On that edge the finish cycle is still counted, result<=dwdata, and the state goes to DUMP with index 0.
  - Timeout: run=1 && cycle_count==MAX_CYCLES-1 with no finish. That cycle is counted, timeout<=1, and the state goes to DONE. There is no dump.
  - Finish and timeout in the same cycle: finish wins and timeout stays 0.
  - Stores to any other address are ignored.
- DUMP:
  - halt=1, mem_sel=1, out_valid=1.
  - dump_addr=out_index=index; out_data=dump_rdata.
  - On out_valid&&out_ready, index+1.
  - When the transfer of index DUMP_WORDS-1 completes, the state goes to DONE.
  - With ready low, index and data hold (the core is halted, so memory is stable).
- DONE:
  - halt=1, done=1, out_valid=0.
  - Counters, result and timeout are frozen until rst.
- rst in any state, including mid-dump: full return to reset values on that edge. An in-flight word is dropped.

## Timing
- Finish detection latency: 1 cycle. halt and mem_sel rise on the edge after the finish store.
- Each dump word takes ≥1 cycle; with out_ready held high, DUMP lasts exactly DUMP_WORDS cycles.
- done rises on the edge after the last handshake, or on the timeout edge.
- All outputs are registered or derived directly from state/index. There is no combinational path from out_ready to out_valid.
- out_data is combinational from dump_rdata (async dmem read).

## Test plan
- Basic finish: run=1 from cycle 0, store 32'h0000_00aa to 32'h7fff after 20 run cycles (store is the 21st). Expect result=32'haa, cycle_count=21, halt high the next cycle, 50 words streamed with out_index 0..49, then done=1.
- Event counts: with N_EVT=4, pulse evt[0] on 5 cycles and evt[3] on 2 cycles, including the finish cycle. Expect evt_count[0]=5, evt_count[3]=2, channels 1 and 2 at 0.
- Backpressure: with DUMP_WORDS=4 and dmem preloaded with 1,2,3,4, toggle out_ready 0/1. Expect exactly 4 handshakes with data 1,2,3,4 in order, and out_data/out_index stable while ready is low.
- Timeout and pause: with MAX_CYCLES=10, hold run low for 3 cycles mid-run and never store to FINISH_ADDR. Expect timeout=1, done=1 and cycle_count=10 after 13 cycles in RUN, with no out_valid.
- Collision and saturation: with MAX_CYCLES=10, make the finish store land on run cycle 10. Expect a dump and timeout=0. Separately, with CNT_W=4 and 20 events, expect the counter to read 4'hf.
- Reset mid-dump: assert rst at out_index=2. Expect everything 0 and IDLE the next cycle; after re-run, the dump restarts from index 0.
